// File: rtl/inst_buf_ctrl.sv
// -----------------------------------------------------------------------------
// inst_buf_ctrl
//
// Pointer and occupancy controller for the dual-write / dual-read instruction
// buffer that sits between IF and ID. Each cycle it decides how many fetched
// instructions (0-2) enter the buffer and how many (0-2) leave toward ID. It
// drives the storage addresses and the back-pressure to IF. The storage array
// lives outside this block.
//
// Parameters
//   DEPTH        number of buffer entries (power of two, >= 4)
//   PTR_W        log2(DEPTH), address width
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   stop         ID stall: blocks issue only, writes still proceed
//   branch_flag  flush request (taken branch / redirect)
//   in_valid     IF offers slot0/slot1 (legal codes 00, 01, 11)
//   out_ready    ID accepts slot0/slot1 (legal codes 00, 01, 11)
//   wr_en        storage write enable per slot
//   wr_addr0/1   storage write addresses (tail, tail+1)
//   rd_addr0/1   storage read addresses (head, head+1)
//   out_valid    head entries valid toward ID
//   count        current occupancy, 0..DEPTH
//   instbuf_full fewer than two free entries; IF must hold off
//   empty        occupancy is zero
//   err_illegal  sticky flag: an illegal in_valid/out_ready code was seen
// -----------------------------------------------------------------------------
module inst_buf_ctrl #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic             branch_flag,
    input  logic [1:0]       in_valid,
    input  logic [1:0]       out_ready,
    output logic [1:0]       wr_en,
    output logic [PTR_W-1:0] wr_addr0,
    output logic [PTR_W-1:0] wr_addr1,
    output logic [PTR_W-1:0] rd_addr0,
    output logic [PTR_W-1:0] rd_addr1,
    output logic [1:0]       out_valid,
    output logic [PTR_W:0]   count,
    output logic             instbuf_full,
    output logic             empty,
    output logic             err_illegal
);

    localparam int CW = PTR_W + 1;
    // Full as soon as fewer than two entries are free, so a two-wide write
    // that has already been accepted can never overflow the array.
    localparam logic [CW-1:0]    FULL_THR     = CW'(DEPTH - 2);
    localparam logic [1:0]       CODE_ILLEGAL = 2'b10;
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             err_q,    err_d;

    logic             in_legal;
    logic             wr_ok;
    logic [1:0]       n_wr;
    logic [1:0]       n_rd;

    // ------------------------------------------------------------------
    // Combinational status and addresses (pointers wrap naturally because
    // DEPTH is a power of two).
    // ------------------------------------------------------------------
    assign wr_addr0     = wr_ptr_q;
    assign wr_addr1     = wr_ptr_q + PTR_ONE;
    assign rd_addr0     = rd_ptr_q;
    assign rd_addr1     = rd_ptr_q + PTR_ONE;
    assign count        = cnt_q;
    assign empty        = (cnt_q == '0);
    assign instbuf_full = (cnt_q > FULL_THR);
    assign err_illegal  = err_q;

    // Writes are all-or-nothing: an illegal offer, a flush or back-pressure
    // suppresses both slots together.
    assign in_legal = (in_valid != CODE_ILLEGAL);
    assign wr_ok    = !branch_flag && !instbuf_full && in_legal;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign wr_en[gi]     = wr_ok & in_valid[gi];
            // Slot gi toward ID is valid once more than gi entries are held.
            assign out_valid[gi] = (cnt_q > CW'(gi));
        end
    endgenerate

    assign n_wr = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};

    // In-order issue. out_ready==10 has bit0 clear, so it falls through to
    // zero without needing its own case.
    always_comb begin
        n_rd = 2'd0;
        if (!(stop || branch_flag)) begin
            if (out_ready == 2'b11 && out_valid == 2'b11) begin
                n_rd = 2'd2;
            end else if (out_ready[0] && out_valid[0]) begin
                n_rd = 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | (in_valid == CODE_ILLEGAL) | (out_ready == CODE_ILLEGAL);
        if (branch_flag) begin
            // Flush wins over stop and over any offered instructions.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-2){1'b0}}, n_wr};
            rd_ptr_d = rd_ptr_q + {{(PTR_W-2){1'b0}}, n_rd};
            cnt_d    = cnt_q + {{(CW-2){1'b0}}, n_wr} - {{(CW-2){1'b0}}, n_rd};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule
